// File: rtl/conv_enc_k3.sv
// -----------------------------------------------------------------------------
// conv_enc_k3 - rate-1/2, constraint-length-3 convolutional encoder
//
// Serial data bits enter through a valid/ready handshake. Each bit produces one
// 2-bit coded symbol {g0, g1}, which leaves through a single output register
// with its own valid/ready handshake.
//
// Build option (macro): CONV_ENC_TAIL_EN
//   defined   : two zero tail bits are appended to every frame, so the shift
//               state returns to 00; out_last marks the second tail pair.
//   undefined : no tail bits; the last data pair carries out_last and the
//               shift state is cleared for the next frame.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_bit/in_last valid
//   in_ready   out  input bit accepted this cycle (combinational on out_ready)
//   in_bit     in   data bit
//   in_last    in   final data bit of the frame
//   out_valid  out  out_pair/out_last valid
//   out_ready  in   downstream accepts the pair
//   out_pair   out  coded symbol {g0, g1}
//   out_last   out  final pair of the frame
//   pair_cnt   out  pairs accepted downstream in the current frame
//   busy       out  frame in progress
// -----------------------------------------------------------------------------
module conv_enc_k3 #(
    parameter logic [2:0] G0    = 3'b111,
    parameter logic [2:0] G1    = 3'b101,
    parameter int          CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_pair,
    output logic             out_last,
    output logic [CNT_W-1:0] pair_cnt,
    output logic             busy
);

    // Generator taps are ordered {current bit, s[1], s[0]}.
    function automatic logic [1:0] encode(input logic [2:0] g0,
                                          input logic [2:0] g1,
                                          input logic       b,
                                          input logic [1:0] s);
        logic [2:0] r;
        r = {b, s};
        return {^(g0 & r), ^(g1 & r)};
    endfunction

`ifdef CONV_ENC_TAIL_EN
    typedef enum logic [1:0] {
        ST_DATA  = 2'd0,
        ST_TAIL1 = 2'd1,
        ST_TAIL2 = 2'd2
    } state_e;

    state_e state_q;
    state_e state_d;
`endif

    logic [1:0]       s_q,         s_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       out_pair_q,  out_pair_d;
    logic             out_last_q,  out_last_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             busy_q,      busy_d;
    logic             clr_q,       clr_d;

    logic             free_s;
    logic             fire_s;
    logic             in_data_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             gen_s;
    logic             gen_bit_s;
    logic             gen_last_s;

    // Handshake decode and choice of which bit (data or tail) is encoded.
    always_comb begin
        free_s     = !out_valid_q || out_ready;
        fire_s     = out_valid_q && out_ready;
`ifdef CONV_ENC_TAIL_EN
        in_data_s  = (state_q == ST_DATA);
`else
        in_data_s  = 1'b1;
`endif
        // rst_n gating keeps in_ready low for the whole reset window.
        in_ready_s = in_data_s && free_s && rst_n;
        accept_s   = in_valid && in_ready_s;
`ifdef CONV_ENC_TAIL_EN
        gen_s      = accept_s || (!in_data_s && free_s);
        gen_bit_s  = in_data_s ? in_bit : 1'b0;
        gen_last_s = (state_q == ST_TAIL2);
        state_d    = state_q;
        case (state_q)
            ST_DATA: begin
                if (accept_s && in_last) begin
                    state_d = ST_TAIL1;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_TAIL1: begin
                if (free_s) begin
                    state_d = ST_TAIL2;
                end else begin
                    state_d = ST_TAIL1;
                end
            end
            ST_TAIL2: begin
                if (free_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_TAIL2;
                end
            end
            default: state_d = ST_DATA;
        endcase
`else
        gen_s      = accept_s;
        gen_bit_s  = in_bit;
        gen_last_s = in_last;
`endif
    end

    // Next-state for shift register, output register, counter and busy flag.
    always_comb begin
        s_d         = s_q;
        out_valid_d = out_valid_q;
        out_pair_d  = out_pair_q;
        out_last_d  = out_last_q;
        if (gen_s) begin
            // A pair accepted in the same cycle is simply overwritten.
            out_valid_d = 1'b1;
            out_pair_d  = encode(G0, G1, gen_bit_s, s_q);
            out_last_d  = gen_last_s;
            // Frame end forces the state to 00 whatever the tail produced.
            s_d         = gen_last_s ? 2'b00 : {gen_bit_s, s_q[1]};
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        // The count shows the full frame total for one cycle, then clears;
        // the clear beats an increment landing in that cycle.
        clr_d = fire_s && out_last_q;
        if (clr_q) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (fire_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        // A new frame starting as the previous one ends keeps busy high.
        if (accept_s) begin
            busy_d = 1'b1;
        end else if (fire_s && out_last_q) begin
            busy_d = 1'b0;
        end else begin
            busy_d = busy_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef CONV_ENC_TAIL_EN
            state_q     <= ST_DATA;
`endif
            s_q         <= 2'b00;
            out_valid_q <= 1'b0;
            out_pair_q  <= 2'b00;
            out_last_q  <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            busy_q      <= 1'b0;
            clr_q       <= 1'b0;
        end else begin
`ifdef CONV_ENC_TAIL_EN
            state_q     <= state_d;
`endif
            s_q         <= s_d;
            out_valid_q <= out_valid_d;
            out_pair_q  <= out_pair_d;
            out_last_q  <= out_last_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            clr_q       <= clr_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_pair  = out_pair_q;
    assign out_last  = out_last_q;
    assign pair_cnt  = cnt_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_conv_enc_k3.sv
// -----------------------------------------------------------------------------
// tb_conv_enc_k3 - self-checking bench for conv_enc_k3 (either build of
// CONV_ENC_TAIL_EN). Directed frames with hand-computed symbol tables, a
// backpressure window, mid-frame reset and long random frames.
// -----------------------------------------------------------------------------
module tb_conv_enc_k3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_bit = 1'b0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_pair;
    logic        out_last;
    logic [15:0] pair_cnt;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int stall_start = -100;
    bit rand_rdy = 1'b0;
    int first_cyc = -1;
    int last_cyc = -1;
    int hold_seen = 0;
    bit hold_pend = 1'b0;
    logic [2:0] hold_val = 3'b000;
    logic [1:0] ms = 2'b00;

    // entries are {last, pair}
    logic [2:0] got_q[$];
    logic [2:0] exp_q[$];

`ifdef CONV_ENC_TAIL_EN
    localparam int TAIL_N = 2;
`else
    localparam int TAIL_N = 0;
`endif

    conv_enc_k3 #(.G0(3'b111), .G1(3'b101), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pair  (out_pair),
        .out_last  (out_last),
        .pair_cnt  (pair_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // out_ready driver: stall window, random or always ready
    always begin
        @(negedge clk);
        cyc++;
        if (cyc >= stall_start && cyc < stall_start + 3) out_ready = 1'b0;
        else if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        else out_ready = 1'b1;
    end

    // output monitor: records accepted pairs, checks hold behaviour
    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (hold_pend) begin
                check_eq("hold_valid", 32'(out_valid), 32'd1);
                check_eq("hold_stable", 32'({out_last, out_pair}), 32'(hold_val));
            end
            if (out_valid && out_ready) begin
                got_q.push_back({out_last, out_pair});
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (out_valid && !out_ready) begin
                check_eq("hold_in_ready", 32'(in_ready), 32'd0);
                hold_seen++;
                hold_pend = 1'b1;
                hold_val  = {out_last, out_pair};
            end else begin
                hold_pend = 1'b0;
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic send(input logic b, input logic l);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_bit   = b;
        in_last  = l;
        #1;
        while (!in_ready && t < 1000) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 1000) check_eq("send_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // wait for frame end, then check pair count holds n for one cycle and clears
    task automatic wait_idle(input string tag, input int n);
        int t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (busy && t < 5000);
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
        check_eq({tag, "_npairs_at_idle"}, 32'(got_q.size()), 32'(n));
        check_eq({tag, "_pair_cnt"}, 32'(pair_cnt), 32'(n));
        @(posedge clk);
        #1;
        check_eq({tag, "_pair_cnt_clr"}, 32'(pair_cnt), 32'd0);
    endtask

    task automatic compare_q(input string tag);
        int n;
        check_eq({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (got_q[i] !== exp_q[i]) begin
                check_eq($sformatf("%s_pair%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
                break;
            end
        end
        if (n > 0) check_eq({tag, "_final"}, 32'(got_q[n-1]), 32'(exp_q[n-1]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send_1011();
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        send(1'b1, 1'b1);
    endtask

    // hand-computed: 11,10,00,01 then tail 01,11
    task automatic exp_1011();
`ifdef CONV_ENC_TAIL_EN
        exp_q = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
`else
        exp_q = '{3'b011, 3'b010, 3'b000, 3'b101};
`endif
    endtask

    // independent reference encoder for the random frames
    task automatic model_bit(input logic b, input logic last);
        logic [2:0] r;
        logic [1:0] p;
        r  = {b, ms};
        p  = {^(r & 3'b111), ^(r & 3'b101)};
        ms = {b, ms[1]};
`ifdef CONV_ENC_TAIL_EN
        exp_q.push_back({1'b0, p});
        if (last) begin
            for (int k = 0; k < 2; k++) begin
                r  = {1'b0, ms};
                p  = {^(r & 3'b111), ^(r & 3'b101)};
                ms = {1'b0, ms[1]};
                exp_q.push_back({(k == 1) ? 1'b1 : 1'b0, p});
            end
        end
`else
        exp_q.push_back({last, p});
        if (last) ms = 2'b00;
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_pair", 32'(out_pair), 32'd0);
        check_eq("rst_out_last", 32'(out_last), 32'd0);
        check_eq("rst_pair_cnt", 32'(pair_cnt), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rel_in_ready", 32'(in_ready), 32'd1);

        // frame 1,0,1,1 with continuous ready
        got_q.delete();
        first_cyc = -1;
        exp_1011();
        send_1011();
        wait_idle("f1011", 4 + TAIL_N);
        check_eq("f1011_consecutive", 32'(last_cyc - first_cyc), 32'(4 + TAIL_N - 1));
        compare_q("f1011");

        // 1-bit frame
        send(1'b1, 1'b1);
        check_eq("f1_busy", 32'(busy), 32'd1);
`ifdef CONV_ENC_TAIL_EN
        exp_q = '{3'b011, 3'b010, 3'b111};
`else
        exp_q = '{3'b111};
`endif
        wait_idle("f1", 1 + TAIL_N);
        compare_q("f1");

        // backpressure window mid-frame
        hold_seen = 0;
        stall_start = cyc + 3;
        exp_1011();
        send_1011();
        wait_idle("bp", 4 + TAIL_N);
        compare_q("bp");
        check_eq("bp_hold_seen", 32'(hold_seen > 0), 32'd1);
        stall_start = -100;

        // reset mid-frame
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("mrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mrst_busy", 32'(busy), 32'd0);
        check_eq("mrst_pair_cnt", 32'(pair_cnt), 32'd0);
        check_eq("mrst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        got_q.delete();
        exp_1011();
        send_1011();
        wait_idle("mrst", 4 + TAIL_N);
        compare_q("mrst");

        // long random frames with random out_ready
        rand_rdy = 1'b1;
        for (int f = 0; f < 2; f++) begin
            logic b;
            ms = 2'b00;
            for (int i = 0; i < 1000; i++) begin
                b = 1'($urandom_range(0, 1));
                model_bit(b, (i == 999) ? 1'b1 : 1'b0);
                send(b, (i == 999) ? 1'b1 : 1'b0);
            end
            wait_idle($sformatf("rnd%0d", f), 1000 + TAIL_N);
            compare_q($sformatf("rnd%0d", f));
        end
        rand_rdy = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
